// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Pipeline control for the 5-stage RV32IM core. Combines three stall/flush
// sources into the PC, IF/ID, ID/EX and EX/MEM register controls:
//   - load-use hazards (one bubble cycle, forwarding covers the rest)
//   - taken branch / jump redirects resolved in EX (squash IF/ID and ID)
//   - the iterative divider: front end frozen for DIV_CYCLES cycles, then
//     one release cycle in which the divide result is captured into EX/MEM.
//
// Handshake: there is no valid/ready pair here. Every control output is a
// combinational function of the current state and inputs and is consumed by
// the pipeline registers at the same rising edge. o_div_start is a single
// cycle pulse; the divider's result is assumed valid exactly DIV_CYCLES
// cycles after that pulse.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_id_rs1/rs2            source register indices of the ID instruction
//   i_id_uses_rs1/rs2       ID instruction actually reads rs1 / rs2
//   i_ex_rd                 destination index of the EX instruction
//   i_ex_mem_read           EX instruction is a load
//   i_ex_is_div             EX instruction is DIV/DIVU/REM/REMU
//   i_ex_redirect           taken branch / JAL / JALR in EX
//   o_pc_enable             PC load enable
//   o_ifid_enable/flush     IF/ID enable and flush
//   o_idex_enable/bubble    ID/EX enable and NOP insert
//   o_exmem_bubble          EX/MEM NOP insert (divide not finished)
//   o_div_start             start pulse to the divider
//   o_stall_count           frozen-front-end cycle counter (wraps)
//   o_dbg_state             FSM state (0 = IDLE, 1 = DIV_BUSY)
//   o_dbg_dcnt              divide down-counter
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
   parameter int DIV_CYCLES = 33,
   parameter int CNT_W      = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [4:0]       i_id_rs1,
   input  logic [4:0]       i_id_rs2,
   input  logic             i_id_uses_rs1,
   input  logic             i_id_uses_rs2,
   input  logic [4:0]       i_ex_rd,
   input  logic             i_ex_mem_read,
   input  logic             i_ex_is_div,
   input  logic             i_ex_redirect,
   output logic             o_pc_enable,
   output logic             o_ifid_enable,
   output logic             o_ifid_flush,
   output logic             o_idex_enable,
   output logic             o_idex_bubble,
   output logic             o_exmem_bubble,
   output logic             o_div_start,
   output logic [31:0]      o_stall_count,
   output logic             o_dbg_state,
   output logic [CNT_W-1:0] o_dbg_dcnt
);

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_DIV_BUSY = 1'b1
   } state_t;

   // The trigger cycle is the first frozen cycle, so the counter starts one
   // short of the full latency and the release happens when it reaches 0.
   localparam logic [CNT_W-1:0] DCNT_LOAD = CNT_W'(DIV_CYCLES - 1);
   localparam logic [CNT_W-1:0] DCNT_ONE  = CNT_W'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_dcnt;
   logic [CNT_W-1:0] w_dcnt_nxt;
   logic [31:0]      r_stall_count;
   logic             w_luh;

   assign w_luh = i_ex_mem_read && (i_ex_rd != 5'd0) &&
                  ((i_id_uses_rs1 && (i_id_rs1 == i_ex_rd)) ||
                   (i_id_uses_rs2 && (i_id_rs2 == i_ex_rd)));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= ST_IDLE;
         r_dcnt        <= '0;
         r_stall_count <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_dcnt  <= w_dcnt_nxt;
         if (!o_pc_enable) begin
            r_stall_count <= r_stall_count + 32'd1;
         end
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_dcnt_nxt     = r_dcnt;
      o_pc_enable    = 1'b1;
      o_ifid_enable  = 1'b1;
      o_ifid_flush   = 1'b0;
      o_idex_enable  = 1'b1;
      o_idex_bubble  = 1'b0;
      o_exmem_bubble = 1'b0;
      o_div_start    = 1'b0;

      if (i_reset) begin
         w_state_nxt    = ST_IDLE;
         w_dcnt_nxt     = '0;
         o_pc_enable    = 1'b0;
         o_ifid_enable  = 1'b0;
         o_idex_enable  = 1'b0;
         o_idex_bubble  = 1'b1;
         o_exmem_bubble = 1'b1;
      end else if ((r_state == ST_IDLE) && i_ex_is_div) begin
         w_state_nxt    = ST_DIV_BUSY;
         w_dcnt_nxt     = DCNT_LOAD;
         o_div_start    = 1'b1;
         o_exmem_bubble = 1'b1;
         o_pc_enable    = 1'b0;
         o_ifid_enable  = 1'b0;
         o_idex_enable  = 1'b0;
      end else if ((r_state == ST_DIV_BUSY) && (r_dcnt != '0)) begin
         w_dcnt_nxt     = r_dcnt - DCNT_ONE;
         o_exmem_bubble = 1'b1;
         o_pc_enable    = 1'b0;
         o_ifid_enable  = 1'b0;
         o_idex_enable  = 1'b0;
      end else begin
         // Release cycle (busy, counter at 0) behaves like an idle cycle,
         // except that i_ex_is_div cannot retrigger on the same instruction.
         if (r_state == ST_DIV_BUSY) begin
            w_state_nxt = ST_IDLE;
            w_dcnt_nxt  = '0;
         end
         if (i_ex_redirect) begin
            // ID instruction is squashed, so a load-use match is irrelevant.
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
         end else if (w_luh) begin
            o_pc_enable   = 1'b0;
            o_ifid_enable = 1'b0;
            o_idex_bubble = 1'b1;
         end
      end
   end

   assign o_stall_count = r_stall_count;
   assign o_dbg_state   = r_state;
   assign o_dbg_dcnt    = r_dcnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

   localparam int DIV_CYCLES = 4;
   localparam int CNT_W      = 8;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       mr;
      logic       div;
      logic       redir;
   } in_t;

   // Field order: pc, ifid_en, ifid_fl, idex_en, idex_bub, exmem_bub, dstart
   typedef struct packed {
      logic pc;
      logic ifid_en;
      logic ifid_fl;
      logic idex_en;
      logic idex_bub;
      logic exmem_bub;
      logic dstart;
   } out_t;

   typedef struct {
      string name;
      in_t   in;
      out_t  exp;
   } vec_t;

   // ---------------- clock / DUT ----------------
   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       rs1, rs2, rd;
   logic             u1, u2, mr, div, redir;
   logic             pc_en, ifid_en, ifid_fl, idex_en, idex_bub, exmem_bub, dstart;
   logic [31:0]      stall_count;
   logic             dbg_state;
   logic [CNT_W-1:0] dbg_dcnt;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_id_rs1(rs1), .i_id_rs2(rs2),
      .i_id_uses_rs1(u1), .i_id_uses_rs2(u2),
      .i_ex_rd(rd), .i_ex_mem_read(mr), .i_ex_is_div(div), .i_ex_redirect(redir),
      .o_pc_enable(pc_en), .o_ifid_enable(ifid_en), .o_ifid_flush(ifid_fl),
      .o_idex_enable(idex_en), .o_idex_bubble(idex_bub),
      .o_exmem_bubble(exmem_bub), .o_div_start(dstart),
      .o_stall_count(stall_count), .o_dbg_state(dbg_state), .o_dbg_dcnt(dbg_dcnt)
   );

   // ---------------- scoreboard counters ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Divide tracked by the cycle number of its trigger: cycles t0..t0+N-1
   // are frozen, cycle t0+N is the release.
   int          m_cyc   = 0;
   int          m_t0    = -1;
   logic [31:0] m_stall = 32'd0;
   bit          m_valid = 1'b0;

   function automatic out_t model_out(input in_t x);
      out_t o;
      bit   luh;
      luh = x.mr && (x.rd != 5'd0) &&
            ((x.u1 && x.rs1 == x.rd) || (x.u2 && x.rs2 == x.rd));
      o = '{pc:1, ifid_en:1, ifid_fl:0, idex_en:1, idex_bub:0, exmem_bub:0, dstart:0};
      if (x.rst)
         o = '{pc:0, ifid_en:0, ifid_fl:0, idex_en:0, idex_bub:1, exmem_bub:1, dstart:0};
      else if (m_t0 < 0 && x.div)
         o = '{pc:0, ifid_en:0, ifid_fl:0, idex_en:0, idex_bub:0, exmem_bub:1, dstart:1};
      else if (m_t0 >= 0 && (m_cyc - m_t0) < DIV_CYCLES)
         o = '{pc:0, ifid_en:0, ifid_fl:0, idex_en:0, idex_bub:0, exmem_bub:1, dstart:0};
      else if (x.redir)
         o = '{pc:1, ifid_en:1, ifid_fl:1, idex_en:1, idex_bub:1, exmem_bub:0, dstart:0};
      else if (luh)
         o = '{pc:0, ifid_en:0, ifid_fl:0, idex_en:1, idex_bub:1, exmem_bub:0, dstart:0};
      return o;
   endfunction

   task automatic model_advance(input in_t x, input out_t o);
      if (x.rst) begin
         m_t0    = -1;
         m_stall = 32'd0;
         m_valid = 1'b1;
      end else begin
         if (m_t0 < 0 && x.div)
            m_t0 = m_cyc;
         else if (m_t0 >= 0 && (m_cyc - m_t0) >= DIV_CYCLES)
            m_t0 = -1;
         if (!o.pc) m_stall = m_stall + 32'd1;
      end
      m_cyc++;
   endtask

   // ---------------- driver ----------------
   // Drive on the falling edge, check 1 ns later, DUT updates on the rising edge.
   task automatic step(input in_t x, output out_t got);
      out_t exp;
      int   exp_dcnt;
      @(negedge clk);
      rst = x.rst; rs1 = x.rs1; rs2 = x.rs2; u1 = x.u1; u2 = x.u2;
      rd = x.rd; mr = x.mr; div = x.div; redir = x.redir;
      #1;
      exp = model_out(x);
      got = '{pc:pc_en, ifid_en:ifid_en, ifid_fl:ifid_fl, idex_en:idex_en,
              idex_bub:idex_bub, exmem_bub:exmem_bub, dstart:dstart};
      chk("outputs", 32'(got), 32'(exp));
      if (m_valid) begin
         exp_dcnt = (m_t0 >= 0) ? (DIV_CYCLES - (m_cyc - m_t0)) : 0;
         chk("stall_count", stall_count, m_stall);
         chk("dbg_state", 32'(dbg_state), 32'(m_t0 >= 0));
         chk("dbg_dcnt", 32'(dbg_dcnt), 32'(exp_dcnt));
      end
      model_advance(x, exp);
   endtask

   function automatic in_t idle_in();
      return '{rst:0, rs1:0, rs2:0, u1:0, u2:0, rd:0, mr:0, div:0, redir:0};
   endfunction

   // ---------------- test ----------------
   vec_t vecs[$];
   in_t  x;
   out_t g;
   int   n_start, n_pc0;

   initial begin
      // Load-use, redirect and default vectors applied from IDLE.
      vecs.push_back('{"luh_rs2", '{rst:0, rs1:0, rs2:5, u1:0, u2:1, rd:5, mr:1, div:0, redir:0},
                       '{pc:0, ifid_en:0, ifid_fl:0, idex_en:1, idex_bub:1, exmem_bub:0, dstart:0}});
      vecs.push_back('{"luh_rd0", '{rst:0, rs1:0, rs2:0, u1:0, u2:1, rd:0, mr:1, div:0, redir:0},
                       '{pc:1, ifid_en:1, ifid_fl:0, idex_en:1, idex_bub:0, exmem_bub:0, dstart:0}});
      vecs.push_back('{"luh_rs1", '{rst:0, rs1:7, rs2:2, u1:1, u2:0, rd:7, mr:1, div:0, redir:0},
                       '{pc:0, ifid_en:0, ifid_fl:0, idex_en:1, idex_bub:1, exmem_bub:0, dstart:0}});
      vecs.push_back('{"rs1_unused", '{rst:0, rs1:7, rs2:2, u1:0, u2:1, rd:7, mr:1, div:0, redir:0},
                       '{pc:1, ifid_en:1, ifid_fl:0, idex_en:1, idex_bub:0, exmem_bub:0, dstart:0}});
      vecs.push_back('{"not_load", '{rst:0, rs1:9, rs2:9, u1:1, u2:1, rd:9, mr:0, div:0, redir:0},
                       '{pc:1, ifid_en:1, ifid_fl:0, idex_en:1, idex_bub:0, exmem_bub:0, dstart:0}});
      vecs.push_back('{"redir_luh", '{rst:0, rs1:0, rs2:5, u1:0, u2:1, rd:5, mr:1, div:0, redir:1},
                       '{pc:1, ifid_en:1, ifid_fl:1, idex_en:1, idex_bub:1, exmem_bub:0, dstart:0}});
      vecs.push_back('{"redir", '{rst:0, rs1:1, rs2:2, u1:1, u2:1, rd:3, mr:0, div:0, redir:1},
                       '{pc:1, ifid_en:1, ifid_fl:1, idex_en:1, idex_bub:1, exmem_bub:0, dstart:0}});
      vecs.push_back('{"default", '{rst:0, rs1:3, rs2:4, u1:1, u2:1, rd:31, mr:1, div:0, redir:0},
                       '{pc:1, ifid_en:1, ifid_fl:0, idex_en:1, idex_bub:0, exmem_bub:0, dstart:0}});

      // Reset held two cycles with a divide pending in EX.
      x = idle_in(); x.rst = 1; x.div = 1;
      for (int i = 0; i < 2; i++) begin
         step(x, g);
         chk("rst_dstart", 32'(g.dstart), 32'd0);
         chk("rst_pc", 32'(g.pc), 32'd0);
         chk("rst_idex_bub", 32'(g.idex_bub), 32'd1);
      end
      chk("rst_stall", stall_count, 32'd0);

      // Divide right after reset, EX_IS_DIV held high through release.
      x.rst = 0;
      n_start = 0; n_pc0 = 0;
      for (int i = 0; i < DIV_CYCLES + 1; i++) begin
         step(x, g);
         if (i == 0) chk("div_first_start", 32'(g.dstart), 32'd1);
         n_start += int'(g.dstart);
         n_pc0   += int'(!g.pc);
      end
      chk("div_release_pc", 32'(g.pc), 32'd1);
      chk("div_release_ifid", 32'(g.ifid_en), 32'd1);
      chk("div_release_idex", 32'(g.idex_en), 32'd1);
      chk("div_release_exmem", 32'(g.exmem_bub), 32'd0);
      chk("div_start_pulses", 32'(n_start), 32'd1);
      chk("div_pc0_cycles", 32'(n_pc0), 32'(DIV_CYCLES));
      step(idle_in(), g);
      chk("div_stall_adv", stall_count, 32'(DIV_CYCLES));

      // Table vectors.
      foreach (vecs[i]) begin
         step(vecs[i].in, g);
         chk(vecs[i].name, 32'(g), 32'(vecs[i].exp));
      end
      step(idle_in(), g);

      // Reset at the second busy cycle: no release, no new start.
      x = idle_in(); x.div = 1;
      step(x, g);
      step(x, g);
      x.rst = 1;
      step(x, g);
      x = idle_in();
      n_start = 0; n_pc0 = 0;
      for (int i = 0; i < 3; i++) begin
         step(x, g);
         if (i == 0) begin
            chk("midrst_state", 32'(dbg_state), 32'd0);
            chk("midrst_dcnt", 32'(dbg_dcnt), 32'd0);
         end
         n_start += int'(g.dstart);
         n_pc0   += int'(!g.pc);
      end
      chk("midrst_no_start", 32'(n_start), 32'd0);
      chk("midrst_no_stall", 32'(n_pc0), 32'd0);

      // Stall counter wrap.
      step(idle_in(), g);
      force dut.r_stall_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_stall_count;
      m_stall = 32'hFFFF_FFFF;
      x = idle_in(); x.mr = 1; x.rd = 5; x.rs2 = 5; x.u2 = 1;
      step(x, g);
      step(idle_in(), g);
      chk("wrap_stall", stall_count, 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         x.rst   = ($urandom_range(0, 49) == 0);
         x.rs1   = 5'($urandom_range(0, 3));
         x.rs2   = 5'($urandom_range(0, 3));
         x.u1    = 1'($urandom_range(0, 1));
         x.u2    = 1'($urandom_range(0, 1));
         x.rd    = 5'($urandom_range(0, 3));
         x.mr    = 1'($urandom_range(0, 1));
         x.div   = ($urandom_range(0, 7) == 0);
         x.redir = ($urandom_range(0, 5) == 0);
         step(x, g);
      end
      step(idle_in(), g);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline control unit for the RV32IM 5-stage core. It generates the PC enable, the IF/ID enable and flush, and the ID/EX bubble from three sources: load-use hazards, taken-branch/jump redirects from EX, and a multi-cycle divide sequencer. The divide sequencer freezes the front end while the iterative divider in EX runs. It sits beside the hazard/forwarding logic and drives the ENABLE/FLUSH inputs of the IF/ID register and the equivalent controls of the PC and ID/EX registers.

## Interface
Parameters:
- DIV_CYCLES, 33: divider latency in cycles, counted from the DIV_START cycle to the cycle its result is valid. Legal range is 2..255.
- CNT_W, 8: width of the internal divide down-counter. Must satisfy 2^CNT_W > DIV_CYCLES.

Ports:
- CLK, input, 1: clock. All state updates on the rising edge.
- RESET, input, 1: synchronous, active-high reset.
- ID_RS1, input, 5: rs1 index of the instruction in ID.
- ID_RS2, input, 5: rs2 index of the instruction in ID.
- ID_USES_RS1, input, 1: ID instruction reads rs1.
- ID_USES_RS2, input, 1: ID instruction reads rs2.
- EX_RD, input, 5: destination index of the instruction in EX.
- EX_MEM_READ, input, 1: EX instruction is a load.
- EX_IS_DIV, input, 1: EX instruction is DIV/DIVU/REM/REMU.
- EX_REDIRECT, input, 1: taken branch, JAL or JALR resolved in EX.
- PC_ENABLE, output, 1: PC register load enable.
- IFID_ENABLE, output, 1: IF/ID register enable.
- IFID_FLUSH, output, 1: IF/ID register flush (NOP insert).
- IDEX_ENABLE, output, 1: ID/EX register enable.
- IDEX_BUBBLE, output, 1: ID/EX loads a NOP instead of the ID instruction.
- EXMEM_BUBBLE, output, 1: EX/MEM loads a NOP (the divide is not yet complete).
- DIV_START, output, 1: one-cycle start pulse to the divider.
- STALL_COUNT, output, 32: count of frozen-front-end cycles (performance counter).

## Operation
- FSM states are IDLE and DIV_BUSY. There is also a CNT_W-bit down-counter DCNT and a 32-bit STALL_COUNT.
- Load-use hazard (luh) = EX_MEM_READ & (EX_RD != 0) & ((ID_USES_RS1 & ID_RS1 == EX_RD) | (ID_USES_RS2 & ID_RS2 == EX_RD)).
- Divide trigger (dtrig) = state IDLE & EX_IS_DIV.
- Output priority, highest first; each row is exclusive:
  - RESET: PC_ENABLE=0, IFID_ENABLE=0, IFID_FLUSH=0, IDEX_ENABLE=0, IDEX_BUBBLE=1, EXMEM_BUBBLE=1, DIV_START=0.
  - dtrig: DIV_START=1, EXMEM_BUBBLE=1, PC_ENABLE=0, IFID_ENABLE=0, IDEX_ENABLE=0. Next state is DIV_BUSY and DCNT loads DIV_CYCLES-1.
  - DIV_BUSY with DCNT != 0: same freeze as dtrig, but DIV_START=0. DCNT decrements.
  - DIV_BUSY with DCNT == 0: the release cycle. All enables are 1 and EXMEM_BUBBLE=0, so the result is captured. Next state is IDLE. EX_REDIRECT, EX_IS_DIV and luh are evaluated per the rows below.
  - EX_REDIRECT: PC_ENABLE=1, IFID_ENABLE=1, IFID_FLUSH=1, IDEX_ENABLE=1, IDEX_BUBBLE=1. luh is ignored because the ID instruction is squashed.
  - luh: PC_ENABLE=0, IFID_ENABLE=0, IFID_FLUSH=0, IDEX_ENABLE=1, IDEX_BUBBLE=1. This lasts exactly one cycle; forwarding resolves the hazard afterwards.
  - Default: all enables 1, all flush/bubble signals 0, DIV_START=0.
- dtrig is never asserted in the release cycle, because state is still DIV_BUSY then. This prevents the divide being re-triggered on its own instruction.
- The EX_IS_DIV value in the release cycle is ignored.
- STALL_COUNT increments by 1 in every non-reset cycle where PC_ENABLE=0. It wraps from 0xFFFFFFFF to 0.
- DCNT is 0 whenever state is IDLE.

## Timing
- All outputs except STALL_COUNT are combinational from the current state and inputs; they are used at the same rising edge.
- Reset values: state IDLE, DCNT=0, STALL_COUNT=0. Outputs are as in the RESET row above.
- Reset asserted mid-divide: at the next edge the state is IDLE and DCNT=0. No release cycle occurs; the divider is reset by the same RESET.
- A divide freezes the front end for exactly DIV_CYCLES cycles (the trigger cycle plus DIV_CYCLES-1 busy cycles), followed by one release cycle.
- Back-to-back divides: a second DIV reaches EX in the cycle after the release cycle and triggers immediately, with no idle gap.
- A load-use hazard costs 1 cycle. A redirect costs 2 squashed instructions: one by IFID_FLUSH and one by IDEX_BUBBLE.

## Test plan
- Reset: hold RESET for 2 cycles while driving EX_IS_DIV=1. Required: DIV_START=0, PC_ENABLE=0, IDEX_BUBBLE=1, STALL_COUNT=0. After release, DIV_START pulses on the first cycle.
- Load-use: EX_MEM_READ=1, EX_RD=5, ID_RS2=5, ID_USES_RS2=1 for one cycle. Required: PC_ENABLE=0, IFID_ENABLE=0, IDEX_BUBBLE=1. Repeat with EX_RD=0: no stall.
- Divide with DIV_CYCLES=4 and EX_IS_DIV held at 1: DIV_START is high for exactly 1 cycle, PC_ENABLE is 0 for 4 cycles, the 5th cycle has all enables 1 and EXMEM_BUBBLE=0, and STALL_COUNT advances by 4.
- Redirect together with luh: EX_REDIRECT=1 with a matching load-use hazard. Required: IFID_FLUSH=1, IDEX_BUBBLE=1, PC_ENABLE=1, and STALL_COUNT unchanged.
- Reset mid-divide: assert RESET at the 2nd busy cycle. Required: IDLE after the edge, with no release cycle and no extra DIV_START.
- Counter wrap: force STALL_COUNT to 0xFFFFFFFF, then cause one luh stall. Required: STALL_COUNT=0.
